// File: rtl/approx_round_stage_if.sv
// Valid/ready bus for the approximate rounding output stage.
// The upstream and downstream handshakes share one bundle.
interface approx_round_stage_if #(
    parameter int IN_W  = 32,
    parameter int SHIFT = 16
);
    localparam int OUT_W = IN_W - SHIFT;

    logic             in_valid;
    logic             in_ready;
    logic [IN_W-1:0]  in_data;
    logic             in_bypass;
    logic             out_valid;
    logic             out_ready;
    logic [OUT_W-1:0] out_data;
    logic             out_sat;

    modport master (
        output in_valid, in_data, in_bypass, out_ready,
        input  in_ready, out_valid, out_data, out_sat
    );

    modport slave (
        input  in_valid, in_data, in_bypass, out_ready,
        output in_ready, out_valid, out_data, out_sat
    );
endinterface

// File: rtl/approx_round_stage.sv
// Two-stage output stage: drop SHIFT low bits, apply approximate 1RS round-up,
// increment with saturation, and count rounding/saturation events.
module approx_round_stage #(
    parameter int IN_W  = 32,
    parameter int SHIFT = 16,
    parameter int CNT_W = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    approx_round_stage_if.slave  bus,
    input  logic                 cnt_clr,
    output logic [CNT_W-1:0]     round_cnt,
    output logic [CNT_W-1:0]     sat_cnt
);
    localparam int OUT_W = IN_W - SHIFT;

    logic             r_s1_valid;
    logic [OUT_W-1:0] r_s1_trunc;
    logic             r_s1_rup;
    logic             r_s2_valid;
    logic [OUT_W-1:0] r_out_data;
    logic             r_out_sat;
    logic             r_s2_rounded;
    logic [CNT_W-1:0] r_round_cnt;
    logic [CNT_W-1:0] r_sat_cnt;

    logic             w_in_ready;
    logic             w_in_xfer;
    logic             w_out_xfer;
    logic             w_s2_load;
    logic [OUT_W-1:0] w_s2_data;
    logic             w_s2_sat;

    // Guard bit set, or the four bits below it all ones; bypass words only truncate.
    function automatic logic f_round_up(input logic [IN_W-1:0] data, input logic bypass);
        logic       g;
        logic [3:0] l;
        g = data[SHIFT-1];
        l = data[SHIFT-2 -: 4];
        return (!bypass) && (g || (&l));
    endfunction

    function automatic logic [CNT_W-1:0] f_sat_inc(input logic [CNT_W-1:0] cnt, input logic inc);
        logic [CNT_W-1:0] res;
        res = cnt;
        if (inc && (cnt != {CNT_W{1'b1}})) begin
            res = cnt + {{(CNT_W-1){1'b0}}, 1'b1};
        end
        return res;
    endfunction

    // in_ready depends only on held state and out_ready, never on in_valid.
    assign w_in_ready = (!r_s1_valid) || (!r_s2_valid) || bus.out_ready;
    assign w_in_xfer  = bus.in_valid && w_in_ready;
    assign w_out_xfer = r_s2_valid && bus.out_ready;
    assign w_s2_load  = r_s1_valid && ((!r_s2_valid) || bus.out_ready);

    // Saturating increment of the truncated word.
    always_comb begin
        w_s2_data = r_s1_trunc + {{(OUT_W-1){1'b0}}, r_s1_rup};
        w_s2_sat  = 1'b0;
        if (r_s1_rup && (&r_s1_trunc)) begin
            w_s2_data = {OUT_W{1'b1}};
            w_s2_sat  = 1'b1;
        end else begin
            w_s2_sat  = 1'b0;
        end
    end

    // Stage 1: capture truncated word and round-up decision.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_valid <= 1'b0;
            r_s1_trunc <= {OUT_W{1'b0}};
            r_s1_rup   <= 1'b0;
        end else if (w_in_xfer) begin
            r_s1_valid <= 1'b1;
            r_s1_trunc <= bus.in_data[IN_W-1:SHIFT];
            r_s1_rup   <= f_round_up(bus.in_data, bus.in_bypass);
        end else if (w_s2_load) begin
            r_s1_valid <= 1'b0;
        end
    end

    // Stage 2: result register, held while the output is stalled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s2_valid   <= 1'b0;
            r_out_data   <= {OUT_W{1'b0}};
            r_out_sat    <= 1'b0;
            r_s2_rounded <= 1'b0;
        end else if (w_s2_load) begin
            r_s2_valid   <= 1'b1;
            r_out_data   <= w_s2_data;
            r_out_sat    <= w_s2_sat;
            r_s2_rounded <= r_s1_rup && (!w_s2_sat);
        end else if (w_out_xfer) begin
            r_s2_valid   <= 1'b0;
        end
    end

    // Event counters advance on delivered words only; clear wins over a same-cycle event.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_round_cnt <= {CNT_W{1'b0}};
            r_sat_cnt   <= {CNT_W{1'b0}};
        end else if (cnt_clr) begin
            r_round_cnt <= {CNT_W{1'b0}};
            r_sat_cnt   <= {CNT_W{1'b0}};
        end else if (w_out_xfer) begin
            r_round_cnt <= f_sat_inc(r_round_cnt, r_s2_rounded);
            r_sat_cnt   <= f_sat_inc(r_sat_cnt, r_out_sat);
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = r_s2_valid;
    assign bus.out_data  = r_out_data;
    assign bus.out_sat   = r_out_sat;
    assign round_cnt     = r_round_cnt;
    assign sat_cnt       = r_sat_cnt;
endmodule

// File: doc/approx_round_stage.md
Name: approx_round_stage

Overview:
- Pipelined output stage placed directly downstream of the approximate multiplier/accumulator datapath.
- Takes a wide unsigned product, drops the low SHIFT bits and applies the team's approximate 1RS round-up rule: round up if the guard bit is set OR the next four lower bits are all ones.
- The rounded result is incremented with saturation and delivered over a valid/ready interface.
- Keeps saturating event counters for rounding and saturation, used for power/accuracy characterisation.

Parameters:
- IN_W, 32, input data width.
- SHIFT, 16, number of low bits dropped; must be >= 5 and < IN_W.
- OUT_W, IN_W-SHIFT, output width; fixed by IN_W and SHIFT, not overridable.
- CNT_W, 16, width of each event counter.

Ports:
- clk  input  1  single clock; all state on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  upstream word valid.
- in_ready  output  1  stage can accept a word this cycle.
- in_data  input  IN_W  unsigned product.
- in_bypass  input  1  sampled with in_data; 1 = truncate only, no round-up.
- out_valid  output  1  out_data valid.
- out_ready  input  1  downstream accepts.
- out_data  output  OUT_W  rounded/saturated result.
- out_sat  output  1  qualifies out_data; the word was saturated.
- cnt_clr  input  1  synchronous clear of both counters.
- round_cnt  output  CNT_W  number of delivered words that were rounded up.
- sat_cnt  output  CNT_W  number of delivered words that saturated.

Behaviour:
- Reset (rst_n low, asynchronous): s1_valid, s2_valid, out_valid, out_sat, out_data, round_cnt and sat_cnt all go to 0. in_ready is 1 once reset is released. Words in flight are discarded.
- Stage 1 (s1) registers:
  - trunc = in_data[IN_W-1:SHIFT]
  - g = in_data[SHIFT-1]
  - l = in_data[SHIFT-2:SHIFT-5]
  - rup = !in_bypass & (g | &l)
- Stage 2 (s2) registers the increment result:
  - If rup and trunc is all ones: out_data = all ones, out_sat = 1.
  - Else: out_data = trunc + rup, out_sat = 0.
  - A per-word "rounded" flag is also kept: rup and not saturated.
- Latency: 2 cycles from input transfer to out_valid when there is no backpressure. Throughput is 1 word/cycle.
- Handshake:
  - Input transfer = in_valid & in_ready. Output transfer = out_valid & out_ready.
  - s2 loads when s1_valid & (!s2_valid | out_ready).
  - s1 loads when in_valid & in_ready.
  - in_ready = !s1_valid | !s2_valid | out_ready. This is combinational from out_ready; no combinational path from in_valid to in_ready.
  - out_valid = s2_valid.
  - While out_valid=1 and out_ready=0, out_data and out_sat are held stable.
  - Under backpressure the stage holds at most 2 words. Order is preserved; no word is dropped or duplicated.
- Bubbles collapse: a valid s1 advances into an empty s2 even while out_ready=0.
- Counters:
  - On each output transfer, round_cnt += rounded flag and sat_cnt += out_sat.
  - Each counter saturates at 2^CNT_W-1 and does not wrap.
  - cnt_clr has priority: a same-cycle event is not counted. cnt_clr does not affect the pipeline.
- Bypass words never round up, so they never saturate.
- Boundary cases:
  - trunc = 0 with rup = 1 -> out_data = 1.
  - in_data = 0 -> out_data = 0, no events counted.

Test Plan:
- IN_W=32, SHIFT=16, in_data 0x0001_8000 -> out_data 0x0002, out_sat 0, 2 cycles later. 0x0001_7800 -> 0x0002 (four-ones rule). 0x0001_7000 -> 0x0001. round_cnt = 2.
- in_data 0xFFFF_8000 -> out_data 0xFFFF, out_sat 1, sat_cnt +1, round_cnt unchanged. Same word with in_bypass=1 -> 0xFFFF, out_sat 0.
- Stream 5 words, out_ready held 0 for 6 cycles -> in_ready drops after 2 accepted; out_data stable while stalled; all 5 words emerge in order once out_ready=1, one per cycle.
- Random valid/ready toggling, 10k words, against a reference model -> zero mismatches, no loss or duplication.
- Preload round_cnt to 2^16-1 via 65535 round-up words, then 1 more -> stays 0xFFFF. Assert cnt_clr in the same cycle as a rounded transfer -> round_cnt = 0.
- Pulse rst_n low with 2 words in flight, asynchronously mid-cycle -> out_valid = 0 immediately, counters 0, in_ready = 1 after release; the next word passes with 2-cycle latency.
